// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin stream arbiter.
package stream_arb_pkg;

  // Arbiter control states: no grant, or a grant register holding a requester.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Requester index width: at least one bit even for tiny N.
  function automatic int unsigned id_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Beat counter width inside a grant; BURST of 2 still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned burst);
    return (clog2(burst) < 1) ? 1 : clog2(burst);
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_pick.sv
// Rotating priority encoder: first set request starting at ptr, wrapping at N.
module rr_priority_pick
  import stream_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [2*N-1:0] w_dbl;
  logic [IDW:0]   w_sum;

  // Rotate the request vector so bit 0 is the pointer position, then take the
  // lowest set bit and map its offset back to an absolute index modulo N.
  always_comb begin
    w_dbl = {req, req} >> ptr;
    any   = 1'b0;
    idx   = '0;
    w_sum = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && w_dbl[j]) begin
        any   = 1'b1;
        w_sum = {1'b0, ptr} + (IDW+1)'(j);
        if (w_sum >= (IDW+1)'(N)) begin
          w_sum = w_sum - (IDW+1)'(N);
        end
        idx = w_sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N stream
// requesters. A grant lasts until the requester's last beat or BURST beats,
// and every granted beat passes through a single output register.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned N     = 4,
  parameter int unsigned BURST = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N*WIDTH-1:0]       s_data,
  input  logic [N-1:0]             s_valid,
  input  logic [N-1:0]             s_last,
  output logic [N-1:0]             s_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [id_width(N)-1:0]   m_id
);

  localparam int unsigned IDW  = id_width(N);
  localparam int unsigned CNTW = cnt_width(BURST);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   r_ptr;
  logic [CNTW-1:0]  r_cnt;

  logic [WIDTH-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_m_last;
  logic [IDW-1:0]   r_m_id;

  logic             w_pick_any;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_out_free;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_accept;
  logic             w_cap;
  logic             w_grant_end;

  rr_priority_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req (s_valid),
    .ptr (r_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign w_out_free = ~r_m_valid | m_ready;

  // Select the granted requester's valid/last/data; loop mux avoids indexing
  // past N when the grant width covers more codes than requesters.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_grant == IDW'(i)) begin
        w_sel_valid = s_valid[i];
        w_sel_last  = s_last[i];
        w_sel_data  = s_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the grantee, and only while the output register is free.
  always_comb begin
    s_ready = '0;
    if (r_state == BUSY) begin
      for (int unsigned i = 0; i < N; i++) begin
        s_ready[i] = (r_grant == IDW'(i)) & w_out_free;
      end
    end
  end

  assign w_accept    = (r_state == BUSY) & w_sel_valid & w_out_free;
  assign w_cap       = (r_cnt == CNTW'(BURST - 1));
  assign w_grant_end = w_accept & (w_sel_last | w_cap);

  // Next-state: grant on any request in IDLE, release after the final beat.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pick_any)  w_state_nxt = BUSY;
      BUSY:    if (w_grant_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant register, beat counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_grant <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      if (r_state == IDLE && w_pick_any) begin
        r_grant <= w_pick_idx;
        r_cnt   <= '0;
      end else if (w_accept && !w_grant_end) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
      if (w_grant_end) begin
        r_ptr <= (r_grant == IDW'(N - 1)) ? '0 : r_grant + IDW'(1);
      end
    end
  end

  // Output register: load on accept, otherwise empty out once drained.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_id    <= '0;
    end else if (w_accept) begin
      r_m_data  <= w_sel_data;
      r_m_valid <= 1'b1;
      r_m_last  <= w_sel_last | w_cap;
      r_m_id    <= r_grant;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_id    = r_m_id;

endmodule
